// File: rtl/mem_common.sv
// Shared front-end fetch / memory types, line geometry and fetch-buffer state encoding.
package mem_common;

  localparam int PADDR_W    = 32;
  localparam int LINE_BYTES = 64;
  localparam int LINE_OFF_W = $clog2(LINE_BYTES);
  localparam int LINE_W     = 8 * LINE_BYTES;
  localparam int FE_ID_W    = 4;

  typedef struct packed {
    logic               valid;
    logic [PADDR_W-1:0] addr;
    logic [FE_ID_W-1:0] id;
  } t_fe_fb_req;

  typedef struct packed {
    logic               valid;
    logic [FE_ID_W-1:0] id;
    logic [PADDR_W-1:0] pc;
    logic [31:0]        instr;
  } t_fb_fe_rsp;

  typedef struct packed {
    logic               valid;
    logic [PADDR_W-1:0] addr;
  } t_fb_mem_req;

  typedef struct packed {
    logic              valid;
    logic [LINE_W-1:0] data;
  } t_mem_fb_rsp;

  typedef enum logic [2:0] {
    FB_IDLE,
    FB_HIT_RSP,
    FB_MISS_REQ,
    FB_WAIT,
    FB_FILL_RSP,
    FB_DROP
  } t_fb_state;

endpackage

// File: rtl/fe_fb_tag_array.sv
// Fully-associative line store for the fetch buffer: tags, valid bits, line data,
// one-hot lookup with word select, and a round-robin fill port.
module fe_fb_tag_array #(
  parameter int NUM_ENTRIES = 4,
  parameter int LINE_BYTES  = 64,
  parameter int PADDR_W     = 32,
  localparam int LINE_W     = 8 * LINE_BYTES,
  localparam int LOFF_W     = $clog2(LINE_BYTES),
  localparam int WIDX_W     = LOFF_W - 2,
  localparam int TAG_W      = PADDR_W - LOFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic [WIDX_W-1:0] lookup_widx,
  output logic              lookup_hit,
  output logic [31:0]       lookup_word,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
  logic [LINE_W-1:0]      data_q [NUM_ENTRIES];
  logic [PTR_W-1:0]       repl_ptr;
  logic [NUM_ENTRIES-1:0] hit_way;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      repl_ptr <= '0;
    end else if (fill_en) begin
      valid_q[repl_ptr] <= 1'b1;
      repl_ptr          <= repl_ptr + PTR_W'(1);
    end
  end

  // Payload needs no reset: an entry is only visible once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[repl_ptr]  <= fill_tag;
      data_q[repl_ptr] <= fill_data;
    end
  end

  // Tags are unique, so OR-ing the masked words yields the single hit word.
  always_comb begin
    hit_way     = '0;
    lookup_word = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit_way[i] = valid_q[i] && (tag_q[i] == lookup_tag);
      if (hit_way[i])
        lookup_word = lookup_word | data_q[i][{lookup_widx, 5'b00000} +: 32];
    end
  end

  assign lookup_hit = |hit_way;

endmodule

// File: rtl/fe_fb.sv
// Fetch buffer: answers single-outstanding fetch requests from a small line buffer,
// filling misses from memory. Optional hit/miss counters under FE_FB_HIT_CNT_EN.
//
// state        | meaning
// FB_IDLE      | ready for a request; lookup done in the accepting cycle
// FB_HIT_RSP   | hit response on the outputs; a new request may be accepted
// FB_MISS_REQ  | line-fill request on the outputs
// FB_WAIT      | waiting for fill data
// FB_FILL_RSP  | response with the filled word on the outputs
// FB_DROP      | flushed while waiting; fill the line, send nothing
module fe_fb #(
  parameter int NUM_ENTRIES = 4,
  parameter int LINE_BYTES  = 64,
  parameter int PADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fe_fb_req_valid,
  input  logic [PADDR_W-1:0]      fe_fb_req_addr,
  input  logic [3:0]              fe_fb_req_id,
  output logic                    fb_fe_rsp_valid,
  output logic [3:0]              fb_fe_rsp_id,
  output logic [PADDR_W-1:0]      fb_fe_rsp_pc,
  output logic [31:0]             fb_fe_rsp_instr,
  input  logic                    flush,
  output logic                    fb_mem_req_valid,
  output logic [PADDR_W-1:0]      fb_mem_req_addr,
  input  logic                    mem_fb_rsp_valid,
  input  logic [8*LINE_BYTES-1:0] mem_fb_rsp_data
`ifdef FE_FB_HIT_CNT_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);

  import mem_common::*;

  localparam int LOFF_W = $clog2(LINE_BYTES);
  localparam int WIDX_W = LOFF_W - 2;
  localparam int TAG_W  = PADDR_W - LOFF_W;

  t_fb_state          state;
  logic [PADDR_W-1:0] req_addr_q;
  logic [3:0]         req_id_q;
  logic               rsp_valid_q;
  logic               mem_req_q;

  logic               accept;
  logic               lookup_hit;
  logic [31:0]        lookup_word;
  logic               fill_en;
  logic [31:0]        fill_word;

  assign accept  = fe_fb_req_valid && !flush &&
                   (state == FB_IDLE || state == FB_HIT_RSP);
  assign fill_en = mem_fb_rsp_valid && (state == FB_WAIT || state == FB_DROP);
  assign fill_word = mem_fb_rsp_data[{req_addr_q[LOFF_W-1:2], 5'b00000} +: 32];

  fe_fb_tag_array #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .LINE_BYTES  (LINE_BYTES),
    .PADDR_W     (PADDR_W)
  ) u_tag_array (
    .clk         (clk),
    .reset       (reset),
    .lookup_tag  (fe_fb_req_addr[PADDR_W-1:LOFF_W]),
    .lookup_widx (fe_fb_req_addr[LOFF_W-1:2]),
    .lookup_hit  (lookup_hit),
    .lookup_word (lookup_word),
    .fill_en     (fill_en),
    .fill_tag    (req_addr_q[PADDR_W-1:LOFF_W]),
    .fill_data   (mem_fb_rsp_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= FB_IDLE;
      req_addr_q      <= '0;
      req_id_q        <= '0;
      rsp_valid_q     <= 1'b0;
      fb_fe_rsp_id    <= '0;
      fb_fe_rsp_pc    <= '0;
      fb_fe_rsp_instr <= '0;
      mem_req_q       <= 1'b0;
      fb_mem_req_addr <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      case (state)
        FB_IDLE, FB_HIT_RSP: begin
          state <= FB_IDLE;
          if (accept) begin
            req_addr_q <= fe_fb_req_addr;
            req_id_q   <= fe_fb_req_id;
            if (lookup_hit) begin
              state           <= FB_HIT_RSP;
              rsp_valid_q     <= 1'b1;
              fb_fe_rsp_id    <= fe_fb_req_id;
              fb_fe_rsp_pc    <= fe_fb_req_addr;
              fb_fe_rsp_instr <= lookup_word;
            end else begin
              state           <= FB_MISS_REQ;
              mem_req_q       <= 1'b1;
              fb_mem_req_addr <= {fe_fb_req_addr[PADDR_W-1:LOFF_W], {LOFF_W{1'b0}}};
            end
          end
        end
        FB_MISS_REQ: state <= flush ? FB_IDLE : FB_WAIT;
        FB_WAIT: begin
          if (mem_fb_rsp_valid) begin
            if (flush) begin
              state <= FB_IDLE;
            end else begin
              state           <= FB_FILL_RSP;
              rsp_valid_q     <= 1'b1;
              fb_fe_rsp_id    <= req_id_q;
              fb_fe_rsp_pc    <= req_addr_q;
              fb_fe_rsp_instr <= fill_word;
            end
          end else if (flush) begin
            state <= FB_DROP;
          end
        end
        FB_FILL_RSP: state <= FB_IDLE;
        FB_DROP:     if (mem_fb_rsp_valid) state <= FB_IDLE;
        default:     state <= FB_IDLE;
      endcase
    end
  end

  // Flush lands on the cycle the pulse is presented, so it gates the registered valids.
  assign fb_fe_rsp_valid  = rsp_valid_q && !(flush && state == FB_FILL_RSP);
  assign fb_mem_req_valid = mem_req_q && !flush;

`ifdef FE_FB_HIT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (lookup_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

  a_no_req_while_busy: assert property (@(posedge clk) disable iff (reset)
    fe_fb_req_valid |-> !(state == FB_MISS_REQ || state == FB_WAIT || state == FB_FILL_RSP));

endmodule

// File: tb/tb_fe_fb.sv
// Scoreboard bench for fe_fb: FIFO-replacement line model, directed cases then random traffic.
module tb_fe_fb;

  logic         clk = 1'b0;
  logic         reset;
  logic         fe_fb_req_valid;
  logic [31:0]  fe_fb_req_addr;
  logic [3:0]   fe_fb_req_id;
  logic         fb_fe_rsp_valid;
  logic [3:0]   fb_fe_rsp_id;
  logic [31:0]  fb_fe_rsp_pc;
  logic [31:0]  fb_fe_rsp_instr;
  logic         flush;
  logic         fb_mem_req_valid;
  logic [31:0]  fb_mem_req_addr;
  logic         mem_fb_rsp_valid;
  logic [511:0] mem_fb_rsp_data;
`ifdef FE_FB_HIT_CNT_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  fe_fb #(.NUM_ENTRIES(4), .LINE_BYTES(64), .PADDR_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .fe_fb_req_valid  (fe_fb_req_valid),
    .fe_fb_req_addr   (fe_fb_req_addr),
    .fe_fb_req_id     (fe_fb_req_id),
    .fb_fe_rsp_valid  (fb_fe_rsp_valid),
    .fb_fe_rsp_id     (fb_fe_rsp_id),
    .fb_fe_rsp_pc     (fb_fe_rsp_pc),
    .fb_fe_rsp_instr  (fb_fe_rsp_instr),
    .flush            (flush),
    .fb_mem_req_valid (fb_mem_req_valid),
    .fb_mem_req_addr  (fb_mem_req_addr),
    .mem_fb_rsp_valid (mem_fb_rsp_valid),
    .mem_fb_rsp_data  (mem_fb_rsp_data)
`ifdef FE_FB_HIT_CNT_EN
    ,
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] pc;
    logic [31:0] instr;
    int unsigned at;
  } exp_rsp_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned at;
  } exp_mem_t;

  exp_rsp_t    q_rsp[$];
  exp_mem_t    q_mem[$];
  logic [31:0] lines[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned mdl_hit = 0;
  int unsigned mdl_miss = 0;
  logic [31:0] bq[$];

  localparam int NUM_ENTRIES = 4;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [511:0] line_of(logic [31:0] la);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = mem_word(la + 32'(4 * i));
    return d;
  endfunction

  function automatic bit mdl_has(logic [31:0] la);
    foreach (lines[i]) if (lines[i] == la) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void mdl_fill(logic [31:0] la);
    if (lines.size() == NUM_ENTRIES) void'(lines.pop_front());
    lines.push_back(la);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_rsp_t er;
    exp_mem_t em;
    if (!reset) begin
      if (fb_fe_rsp_valid) begin
        if (q_rsp.size() == 0) begin
          n_chk++;
          $display("FAIL rsp_unexpected: got rsp id %0h pc %0h, required no rsp (cycle %0d)",
                   fb_fe_rsp_id, fb_fe_rsp_pc, cyc);
        end else begin
          er = q_rsp.pop_front();
          check("rsp_id", 64'(fb_fe_rsp_id), 64'(er.id));
          check("rsp_pc", 64'(fb_fe_rsp_pc), 64'(er.pc));
          check("rsp_instr", 64'(fb_fe_rsp_instr), 64'(er.instr));
          check("rsp_cycle", 64'(cyc), 64'(er.at));
        end
      end
      if (fb_mem_req_valid) begin
        if (q_mem.size() == 0) begin
          n_chk++;
          $display("FAIL mem_unexpected: got mem req %0h, required no req (cycle %0d)",
                   fb_mem_req_addr, cyc);
        end else begin
          em = q_mem.pop_front();
          check("mem_addr", 64'(fb_mem_req_addr), 64'(em.addr));
          check("mem_cycle", 64'(cyc), 64'(em.at));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal, 1 flush with request, 2 flush in wait, 3 flush with fill,
  //       4 flush on fill response, 5 flush on memory request
  task automatic txn(input logic [31:0] addr, input logic [3:0] id, input int mode, input int d);
    logic [31:0] la;
    bit          hit;
    la  = {addr[31:6], 6'b0};
    hit = mdl_has(la);
    fe_fb_req_valid = 1'b1;
    fe_fb_req_addr  = addr;
    fe_fb_req_id    = id;
    flush           = (mode == 1);
    tick();
    fe_fb_req_valid = 1'b0;
    flush           = 1'b0;
    if (mode == 1) begin
      tick();
      tick();
      return;
    end
    if (hit) begin
      mdl_hit++;
      q_rsp.push_back('{id: id, pc: addr, instr: mem_word({addr[31:2], 2'b00}), at: cyc});
      tick();
      return;
    end
    mdl_miss++;
    if (mode == 5) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      return;
    end
    q_mem.push_back('{addr: la, at: cyc});
    tick();
    if (mode == 2) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    repeat (d) tick();
    mem_fb_rsp_valid = 1'b1;
    mem_fb_rsp_data  = line_of(la);
    flush            = (mode == 3);
    if (mode == 0)
      q_rsp.push_back('{id: id, pc: addr, instr: mem_word({addr[31:2], 2'b00}), at: cyc + 1});
    mdl_fill(la);
    tick();
    mem_fb_rsp_valid = 1'b0;
    mem_fb_rsp_data  = $urandom();
    flush            = (mode == 4);
    tick();
    flush = 1'b0;
  endtask

  // Back-to-back requests from bq; every address must already be resident.
  task automatic burst();
    logic [31:0] a;
    logic [3:0]  id;
    while (bq.size() > 0) begin
      a  = bq.pop_front();
      id = 4'($urandom_range(0, 15));
      fe_fb_req_valid = 1'b1;
      fe_fb_req_addr  = a;
      fe_fb_req_id    = id;
      tick();
      mdl_hit++;
      q_rsp.push_back('{id: id, pc: a, instr: mem_word({a[31:2], 2'b00}), at: cyc});
    end
    fe_fb_req_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    lines.delete();
    mdl_hit  = 0;
    mdl_miss = 0;
  endtask

  task automatic check_counters(input string nm);
`ifdef FE_FB_HIT_CNT_EN
    check({nm, "_hit_cnt"}, 64'(hit_cnt), 64'(mdl_hit));
    check({nm, "_miss_cnt"}, 64'(miss_cnt), 64'(mdl_miss));
`endif
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    int          mode;
    reset            = 1'b1;
    fe_fb_req_valid  = 1'b0;
    fe_fb_req_addr   = '0;
    fe_fb_req_id     = '0;
    flush            = 1'b0;
    mem_fb_rsp_valid = 1'b0;
    mem_fb_rsp_data  = '0;
    do_reset();

    check("reset_rsp_valid", 64'(fb_fe_rsp_valid), 64'd0);
    check("reset_rsp_id", 64'(fb_fe_rsp_id), 64'd0);
    check("reset_rsp_pc", 64'(fb_fe_rsp_pc), 64'd0);
    check("reset_rsp_instr", 64'(fb_fe_rsp_instr), 64'd0);
    check("reset_mem_valid", 64'(fb_mem_req_valid), 64'd0);
    check("reset_mem_addr", 64'(fb_mem_req_addr), 64'd0);
    check_counters("reset");

    txn(32'h0000_0100, 4'd3, 0, 3);
    bq.push_back(32'h0000_0104);
    bq.push_back(32'h0000_0108);
    burst();

    do_reset();
    txn(32'h0000_0000, 4'd1, 0, 1);
    txn(32'h0000_0040, 4'd2, 0, 0);
    txn(32'h0000_0080, 4'd4, 0, 2);
    txn(32'h0000_00C0, 4'd5, 0, 1);
    txn(32'h0000_0100, 4'd6, 0, 0);
    txn(32'h0000_0000, 4'd7, 0, 1);
    txn(32'h0000_0044, 4'd8, 0, 1);

    txn(32'h0000_0200, 4'd9, 2, 2);
    txn(32'h0000_0204, 4'd10, 0, 0);
    txn(32'h0000_0300, 4'd11, 1, 0);
    txn(32'h0000_0300, 4'd12, 5, 0);
    txn(32'h0000_0340, 4'd13, 3, 1);
    txn(32'h0000_0348, 4'd13, 0, 0);
    txn(32'h0000_0380, 4'd14, 4, 0);
    txn(32'h0000_03BC, 4'd15, 0, 0);
    check_counters("directed");

    fe_fb_req_valid = 1'b1;
    fe_fb_req_addr  = 32'h7000_0010;
    fe_fb_req_id    = 4'd2;
    tick();
    fe_fb_req_valid = 1'b0;
    q_mem.push_back('{addr: 32'h7000_0000, at: cyc});
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lines.delete();
    mdl_hit  = 0;
    mdl_miss = 0;
    mem_fb_rsp_valid = 1'b1;
    mem_fb_rsp_data  = line_of(32'h7000_0000);
    tick();
    mem_fb_rsp_valid = 1'b0;
    tick();
    tick();
    check_counters("reset_mid_wait");
    txn(32'h7000_0010, 4'd6, 0, 1);

    for (int i = 0; i < 300; i++) begin
      if (lines.size() > 0 && $urandom_range(0, 7) == 0) begin
        for (int k = 0; k < int'($urandom_range(2, 4)); k++) begin
          a = lines[$urandom_range(0, lines.size() - 1)];
          bq.push_back(a + 32'(4 * $urandom_range(0, 15)));
        end
        burst();
      end else begin
        a = 32'h0000_1000 + 32'(64 * $urandom_range(0, 7)) + 32'(4 * $urandom_range(0, 15));
        r = $urandom_range(0, 9);
        if (r <= 5)      mode = 0;
        else if (r == 6) mode = 1;
        else if (r == 7) mode = 2;
        else if (r == 8) mode = 3;
        else             mode = $urandom_range(0, 1) ? 4 : 5;
        txn(a, 4'($urandom_range(0, 15)), mode, $urandom_range(0, 4));
      end
    end
    tick();
    tick();
    check_counters("final");
    check("rsp_queue_drained", 64'(q_rsp.size()), 64'd0);
    check("mem_queue_drained", 64'(q_mem.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fe_fb.md
Name: fe_fb

Overview:
- Fetch buffer: the responder side of the front-end fetch request/response protocol.
- Accepts single-outstanding instruction fetch requests (valid/addr/id) from fetch control.
- Serves each request from a small fully-associative line buffer. On a miss it issues one line-fill request to memory.
- Returns one 32-bit instruction plus its PC per request. In-flight responses are cancelled on branch mispredict or nuke.

Parameters:
- NUM_ENTRIES, 4, line-buffer entries (power of 2, >=2).
- LINE_BYTES, 64, bytes per line; line data width = 8*LINE_BYTES.
- PADDR_W, 32, physical address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fe_fb_req_valid  in  1  fetch request valid
- fe_fb_req_addr  in  PADDR_W  instruction byte address (4-byte aligned)
- fe_fb_req_id  in  4  requester tag, echoed in the response
- fb_fe_rsp_valid  out  1  response valid (single-cycle pulse)
- fb_fe_rsp_id  out  4  echoed id
- fb_fe_rsp_pc  out  PADDR_W  echoed request address
- fb_fe_rsp_instr  out  32  instruction word
- flush  in  1  br_mispred_ex0.valid | nuke_rb1.valid
- fb_mem_req_valid  out  1  line-fill request (single-cycle pulse)
- fb_mem_req_addr  out  PADDR_W  line-aligned address, low log2(LINE_BYTES) bits = 0
- mem_fb_rsp_valid  in  1  fill data valid
- mem_fb_rsp_data  in  8*LINE_BYTES  line data; byte 0 in bits [7:0]

Behaviour:
- Reset:
  - All entries invalid; FSM in FB_IDLE; replacement pointer = 0.
  - All outputs 0; any captured request discarded.
  - Reset mid-miss: an arriving mem_fb_rsp is ignored.
- Address split:
  - tag = addr[PADDR_W-1 : log2(LINE_BYTES)].
  - Word index = addr[log2(LINE_BYTES)-1 : 2].
  - instr = line word[index]; bits [1:0] are ignored.
- FSM states: FB_IDLE, FB_HIT_RSP, FB_MISS_REQ, FB_WAIT, FB_FILL_RSP, FB_DROP.
- FB_IDLE:
  - A request is accepted when fe_fb_req_valid & ~flush. Capture addr/id.
  - Tag lookup is done the same cycle. Hit -> FB_HIT_RSP. Miss -> FB_MISS_REQ.
  - A request arriving in the same cycle as flush is dropped; stay in FB_IDLE.
- FB_HIT_RSP:
  - Drive fb_fe_rsp_valid=1 with captured id/pc and the word from the hit entry (data registered at lookup).
  - Next state FB_IDLE. Hit latency: request at cycle N, response at N+1.
  - A new request is accepted in this cycle (back-to-back), supporting the fetch side's early-send path.
- FB_MISS_REQ:
  - Pulse fb_mem_req_valid with the line address. Next state FB_WAIT.
  - flush here suppresses the memory request -> FB_IDLE.
- FB_WAIT:
  - On mem_fb_rsp_valid: write the line into entry[repl_ptr], mark it valid, capture the word, increment repl_ptr (wraps NUM_ENTRIES-1 -> 0). Next state FB_FILL_RSP.
  - flush without mem rsp -> FB_DROP.
  - flush in the same cycle as mem rsp: the line is filled, no response is sent -> FB_IDLE.
- FB_FILL_RSP:
  - Pulse fb_fe_rsp_valid with the filled word. Next state FB_IDLE.
  - flush this cycle suppresses valid.
  - New requests are not accepted in this state.
- FB_DROP:
  - On mem_fb_rsp_valid: fill the entry (the line stays useful); no fe response -> FB_IDLE.
  - Requests arriving in FB_DROP are ignored; the fetch side guarantees none arrive while a nuke is pending.
- Requests in FB_MISS_REQ/FB_WAIT/FB_FILL_RSP are illegal and are asserted against.
- Duplicate tags can never exist: a fill only follows a miss, and flush does not invalidate entries.
- At most one memory request is outstanding at any time.

Optional Feature:
- FE_FB_HIT_CNT_EN defined:
  - Adds outputs hit_cnt (32) and miss_cnt (32), reset to 0.
  - Each accepted request increments exactly one of them; both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- mem_common package holds:
  - the request/response structs t_fe_fb_req {valid, addr, id} and t_fb_fe_rsp {valid, id, pc, instr};
  - t_fb_mem_req, t_mem_fb_rsp;
  - LINE_BYTES, LINE_OFF_W, t_fb_state.
- One sub-module, fe_fb_tag_array, holds the tags, valid bits, data, and round-robin pointer:
  - one-hot lookup hit/way and read word out;
  - fill write port.

Test Plan:
- Cold miss: reset, req addr 0x0000_0100 id 3 -> mem req 0x0000_0100 at N+1; mem rsp at N+5 with word 0 = 0x0000_0013 -> fe rsp at N+6: id 3, pc 0x100, instr 0x0000_0013.
- Hit streak: after the above, req 0x104 and 0x108 on back-to-back cycles -> responses on each following cycle with words 1 and 2; no mem req.
- Replacement: fill lines 0x000, 0x040, 0x080, 0x0C0, 0x100 -> 0x000 evicted; re-req 0x000 triggers a mem req.
- Flush in FB_WAIT: miss 0x200, flush at N+3, mem rsp at N+6 -> no fe rsp; later req 0x204 hits with latency 1.
- Flush coincident with req 0x300 in FB_IDLE -> no mem req, no rsp, state stays FB_IDLE.
- Reset while in FB_WAIT, then mem rsp arrives -> entries remain invalid, no rsp; with FE_FB_HIT_CNT_EN, both counters are 0.
